// File: rtl/ppm_demod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ppm_demod                                                    |
// | Description : PPM receiver; measures marker-to-data delay in slots and     |
// |               emits one symbol strobe or one error strobe per frame.       |
// |               Optional statistics counters: PPM_DEMOD_STATS_EN.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ppm_demod #(
    parameter int SYMBOL_BITS  = 4,
    parameter int SLOT_LOG2    = 2,
    parameter int GUARD_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   ppm_in,
    output logic [SYMBOL_BITS-1:0] sym_data,
    output logic                   sym_valid,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic                   busy,
    output logic [7:0]             sym_count,
    output logic [7:0]             err_count
);

    localparam int c_slot_cycles = 1 << SLOT_LOG2;
    localparam int c_maxd        = ((1 << SYMBOL_BITS) + 1) * c_slot_cycles;
    localparam int c_cnt_w       = $clog2(c_maxd) + 1;
    localparam int c_gcnt_w      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_slot  = c_cnt_w'(c_slot_cycles);
    localparam logic [c_cnt_w-1:0]  c_cnt_tmo   = c_cnt_w'(c_maxd - 1);
    localparam logic [c_gcnt_w-1:0] c_gcnt_load = c_gcnt_w'(GUARD_CYCLES - 1);
    localparam logic [c_gcnt_w-1:0] c_gcnt_one  = c_gcnt_w'(1);

    localparam logic [1:0] c_code_early   = 2'b01;
    localparam logic [1:0] c_code_timeout = 2'b10;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_measure = 2'd1;
    localparam logic [1:0] c_st_guard   = 2'd2;

    logic                   r_s1;
    logic                   r_s2;
    logic                   r_sd;
    logic                   w_rise;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [c_gcnt_w-1:0]    r_gcnt;
    logic [c_gcnt_w-1:0]    w_gcnt_nxt;

    logic [SYMBOL_BITS-1:0] r_sym_data;
    logic [SYMBOL_BITS-1:0] w_sym_nxt;
    logic                   r_sym_valid;
    logic                   w_valid_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic [1:0]             r_err_code;
    logic [1:0]             w_err_code_nxt;

    // ppm_in is asynchronous; only the synchronised copy is ever observed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_sd <= 1'b0;
        end else begin
            r_s1 <= ppm_in;
            r_s2 <= r_s1;
            r_sd <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_sd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_gcnt      <= '0;
            r_sym_data  <= '0;
            r_sym_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_sym_data  <= w_sym_nxt;
            r_sym_valid <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_gcnt_nxt     = r_gcnt;
        w_sym_nxt      = r_sym_data;
        w_valid_nxt    = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;

        if (!en) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_rise) begin
                        w_state_nxt = c_st_measure;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end

                c_st_measure: begin
                    // a data edge wins over a coincident timeout
                    if (w_rise) begin
                        w_state_nxt = c_st_guard;
                        w_gcnt_nxt  = c_gcnt_load;
                        w_cnt_nxt   = '0;
                        if (r_cnt < c_cnt_slot) begin
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = c_code_early;
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_sym_nxt   = SYMBOL_BITS'((r_cnt >> SLOT_LOG2) - c_cnt_one);
                        end
                    end else if (r_cnt == c_cnt_tmo) begin
                        w_state_nxt    = c_st_guard;
                        w_gcnt_nxt     = c_gcnt_load;
                        w_cnt_nxt      = '0;
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = c_code_timeout;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end

                c_st_guard: begin
                    if (r_gcnt == '0) begin
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_gcnt_nxt = r_gcnt - c_gcnt_one;
                    end
                end

                default: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign sym_data  = r_sym_data;
    assign sym_valid = r_sym_valid;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign busy      = (r_state != c_st_idle);

`ifdef PPM_DEMOD_STATS_EN
    logic [7:0] r_sym_count;
    logic [7:0] r_err_count;

    // saturating, and deliberately not cleared by en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_count <= 8'd0;
            r_err_count <= 8'd0;
        end else begin
            if (r_sym_valid && (r_sym_count != 8'hFF)) begin
                r_sym_count <= r_sym_count + 8'd1;
            end
            if (r_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign sym_count = r_sym_count;
    assign err_count = r_err_count;
`else
    assign sym_count = 8'd0;
    assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppm_demod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ppm_demod                                                 |
// | Description : Randomised frame-level bench for ppm_demod with a delay-to-  |
// |               symbol reference model.                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ppm_demod;

    localparam int c_sym_bits = 4;
    localparam int c_slot     = 4;
    localparam int c_guard    = 8;
    localparam int c_maxd     = ((1 << c_sym_bits) + 1) * c_slot;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic                  ppm_in;
    logic [c_sym_bits-1:0] sym_data;
    logic                  sym_valid;
    logic                  err;
    logic [1:0]            err_code;
    logic                  busy;
    logic [7:0]            sym_count;
    logic [7:0]            err_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [c_sym_bits-1:0] m_last_sym;
    int                    m_sym_cnt;
    int                    m_err_cnt;

    ppm_demod #(
        .SYMBOL_BITS  (c_sym_bits),
        .SLOT_LOG2    (2),
        .GUARD_CYCLES (c_guard)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ppm_in    (ppm_in),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy),
        .sym_count (sym_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef PPM_DEMOD_STATS_EN
        check_eq("sym_count", 32'(sym_count), 32'((m_sym_cnt > 255) ? 255 : m_sym_cnt));
        check_eq("err_count", 32'(err_count), 32'((m_err_cnt > 255) ? 255 : m_err_cnt));
`else
        check_eq("sym_count_off", 32'(sym_count), 32'd0);
        check_eq("err_count_off", 32'(err_count), 32'd0);
`endif
    endtask

    // One frame on the pin: marker at k=0, data rise at k=delta (none if tmo),
    // optional stray rise at k=poke that must fall inside the guard window.
    // Frame-level rules: the strobe appears 3 cycles after the deciding pin
    // edge (2 sync + 1 register); delays below one slot are early errors;
    // no data within MAXD-1 cycles is a timeout.
    task automatic run_frame(input int delta, input bit tmo, input int mw, input int dw, input int poke);
        int                    e;
        int                    n_valid;
        int                    n_err;
        int                    n_both;
        bit                    exp_valid;
        logic [c_sym_bits-1:0] exp_sym;
        logic [1:0]            exp_code;
        bit                    pin;

        e         = tmo ? (c_maxd - 1) : delta;
        exp_valid = !tmo && (delta >= c_slot);
        exp_sym   = c_sym_bits'((delta / c_slot) - 1);
        exp_code  = tmo ? 2'b10 : 2'b01;
        n_valid   = 0;
        n_err     = 0;
        n_both    = 0;

        for (int k = 0; k <= e + 3 + c_guard; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_valid += int'(sym_valid);
                n_err   += int'(err);
                n_both  += int'(sym_valid & err);
            end
            if (k == 3) check_eq("busy_measure", 32'(busy), 32'd1);
            if (k == e + 3) begin
                if (exp_valid) begin
                    check_eq("sym_valid", 32'(sym_valid), 32'd1);
                    check_eq("sym_data", 32'(sym_data), 32'(exp_sym));
                end else begin
                    check_eq("err", 32'(err), 32'd1);
                    check_eq("err_code", 32'(err_code), 32'(exp_code));
                    check_eq("sym_data_hold", 32'(sym_data), 32'(m_last_sym));
                end
            end
            if (k == e + 2 + c_guard) check_eq("busy_guard_end", 32'(busy), 32'd1);
            if (k == e + 3 + c_guard) check_eq("busy_idle", 32'(busy), 32'd0);

            pin = (k < mw);
            if (!tmo && k >= delta && k < delta + dw) pin = 1'b1;
            if (poke > 0 && k == poke) pin = 1'b1;
            ppm_in = pin;
        end

        check_eq("n_valid", 32'(n_valid), exp_valid ? 32'd1 : 32'd0);
        check_eq("n_err", 32'(n_err), exp_valid ? 32'd0 : 32'd1);
        check_eq("no_overlap", 32'(n_both), 32'd0);

        if (exp_valid) begin
            m_last_sym = exp_sym;
            m_sym_cnt++;
        end else begin
            m_err_cnt++;
        end
        check_stats();
    endtask

    task automatic run_random_frame();
        int  delta;
        bit  tmo;
        int  mw;
        int  dw;
        int  poke;
        int  lo;
        int  hi;
        int  sel;

        sel   = int'($urandom_range(9, 0));
        tmo   = (sel == 0);
        delta = (sel == 1) ? int'($urandom_range(3, 2)) : int'($urandom_range(c_maxd - 1, c_slot));
        mw    = tmo ? int'($urandom_range(4, 1)) : int'($urandom_range((delta - 1 < 4) ? delta - 1 : 4, 1));
        dw    = int'($urandom_range(3, 1));
        lo    = tmo ? c_maxd : delta + dw + 1;
        hi    = (tmo ? c_maxd - 1 : delta) + 7;
        poke  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(hi, lo)) : 0;
        run_frame(delta, tmo, mw, dw, poke);
    endtask

    task automatic reset_abort();
        int n_strobe;
        n_strobe = 0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            ppm_in = (k == 0);
        end
        rst_n = 1'b0;
        #1;
        check_eq("rst_sym_data", 32'(sym_data), 32'd0);
        check_eq("rst_sym_valid", 32'(sym_valid), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_err_code", 32'(err_code), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sym_count", 32'(sym_count), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_last_sym = '0;
        m_sym_cnt  = 0;
        m_err_cnt  = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            n_strobe += int'(sym_valid | err);
        end
        check_eq("rst_no_strobe", 32'(n_strobe), 32'd0);
        check_eq("rst_busy_after", 32'(busy), 32'd0);
    endtask

    task automatic en_abort();
        int n_strobe;
        n_strobe = 0;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (k > 0) n_strobe += int'(sym_valid | err);
            if (k == 21) check_eq("en_abort_busy", 32'(busy), 32'd0);
            if (k == 28) check_eq("en_low_ignore", 32'(busy), 32'd0);
            ppm_in = (k == 0) || (k == 22);
            if (k == 20) en = 1'b0;
            if (k == 30) en = 1'b1;
        end
        check_eq("en_no_strobe", 32'(n_strobe), 32'd0);
        check_eq("en_sym_hold", 32'(sym_data), 32'(m_last_sym));
        check_stats();
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        ppm_in     = 1'b0;
        m_last_sym = '0;
        m_sym_cnt  = 0;
        m_err_cnt  = 0;

        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_sym_data", 32'(sym_data), 32'd0);
        check_eq("reset_sym_valid", 32'(sym_valid), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        check_eq("reset_err_code", 32'(err_code), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(24, 1'b0, 2, 1, 0);
        run_frame(27, 1'b0, 1, 2, 0);
        run_frame(64, 1'b0, 3, 1, 0);
        run_frame(3,  1'b0, 1, 1, 7);
        run_frame(0,  1'b1, 2, 1, 70);
        run_frame(4,  1'b0, 1, 1, 0);
        run_frame(67, 1'b0, 4, 3, 0);
        run_frame(2,  1'b0, 1, 1, 6);
        run_frame(24, 1'b0, 2, 1, 0);

        reset_abort();
        en_abort();
        run_frame(4,  1'b0, 1, 1, 0);
        run_frame(40, 1'b0, 2, 1, 0);
        run_frame(3,  1'b0, 2, 1, 0);
        run_frame(13, 1'b0, 1, 1, 18);
        run_frame(0,  1'b1, 1, 1, 0);

        for (int i = 0; i < 300; i++) begin
            run_random_frame();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
